// File: rtl/fp_normaliser_pipe.sv
// Two-stage floating-point normaliser with valid/ready handshakes at both ends.
// Optional macro NORM_STICKY_EN keeps the bit lost on the carry right shift as a sticky LSB.
module fp_normaliser_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] input_e,
    input  logic [MAN_W-1:0] input_m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] output_e,
    output logic [MAN_W-1:0] output_m,
    output logic [2:0]       flags
);

    localparam int LZ_W = $clog2(MAN_W);
    localparam int CMP_W = EXP_W + LZ_W;
    localparam logic [EXP_W-1:0] EXP_LIMIT = {{(EXP_W-1){1'b1}}, 1'b0};

    logic             s1Load, s2Load;
    logic [LZ_W-1:0]  inLz;

    logic             s1Valid_q, s1Valid_d;
    logic [LZ_W-1:0]  s1Lz_q, s1Lz_d;
    logic             s1Carry_q, s1Carry_d;
    logic             s1Zero_q, s1Zero_d;
    logic [EXP_W-1:0] s1Exp_q, s1Exp_d;
    logic [MAN_W-1:0] s1Man_q, s1Man_d;

    logic             outValid_q, outValid_d;
    logic [EXP_W-1:0] outExp_q, outExp_d;
    logic [MAN_W-1:0] outMan_q, outMan_d;
    logic [2:0]       flags_q, flags_d;

    logic [EXP_W-1:0] resExp;
    logic [MAN_W-1:0] resMan, rightMan, leftMan;
    logic [2:0]       resFlags;
    logic [CMP_W-1:0] lowExp;

    assign s2Load   = !outValid_q || out_ready;
    assign s1Load   = !s1Valid_q || s2Load;
    assign in_ready = s1Load;

    // Leading zeros below the carry bit; the highest set bit wins.
    always_comb begin
        inLz = LZ_W'(MAN_W - 1);
        for (int i = 0; i < MAN_W - 1; i++) begin
            if (input_m[i]) begin
                inLz = LZ_W'(MAN_W - 2 - i);
            end
        end
    end

    always_comb begin
        s1Valid_d = s1Valid_q;
        s1Lz_d    = s1Lz_q;
        s1Carry_d = s1Carry_q;
        s1Zero_d  = s1Zero_q;
        s1Exp_d   = s1Exp_q;
        s1Man_d   = s1Man_q;
        if (s1Load) begin
            s1Valid_d = in_valid;
            s1Lz_d    = inLz;
            s1Carry_d = input_m[MAN_W-1];
            s1Zero_d  = (input_m == '0);
            s1Exp_d   = input_e;
            s1Man_d   = input_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Lz_q    <= '0;
            s1Carry_q <= 1'b0;
            s1Zero_q  <= 1'b0;
            s1Exp_q   <= '0;
            s1Man_q   <= '0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s1Lz_q    <= s1Lz_d;
            s1Carry_q <= s1Carry_d;
            s1Zero_q  <= s1Zero_d;
            s1Exp_q   <= s1Exp_d;
            s1Man_q   <= s1Man_d;
        end
    end

    // Zero beats underflow beats normal; overflow only arises on the carry path.
    always_comb begin
        rightMan = s1Man_q >> 1;
`ifdef NORM_STICKY_EN
        rightMan[0] = rightMan[0] | s1Man_q[0];
`endif
        leftMan  = s1Man_q << s1Lz_q;
        lowExp   = CMP_W'(s1Exp_q) - CMP_W'(s1Lz_q);
        resExp   = s1Exp_q;
        resMan   = s1Man_q;
        resFlags = 3'b000;
        if (s1Zero_q) begin
            resExp   = '0;
            resMan   = '0;
            resFlags = 3'b001;
        end else if (s1Carry_q) begin
            if (s1Exp_q >= EXP_LIMIT) begin
                resExp   = '1;
                resMan   = '0;
                resFlags = 3'b100;
            end else begin
                resExp = s1Exp_q + EXP_W'(1);
                resMan = rightMan;
            end
        end else if (CMP_W'(s1Lz_q) >= CMP_W'(s1Exp_q)) begin
            resExp   = '0;
            resMan   = '0;
            resFlags = 3'b010;
        end else begin
            resExp = lowExp[EXP_W-1:0];
            resMan = leftMan;
        end
    end

    always_comb begin
        outValid_d = outValid_q;
        outExp_d   = outExp_q;
        outMan_d   = outMan_q;
        flags_d    = flags_q;
        if (s2Load) begin
            outValid_d = s1Valid_q;
            if (s1Valid_q) begin
                outExp_d = resExp;
                outMan_d = resMan;
                flags_d  = resFlags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outExp_q   <= '0;
            outMan_q   <= '0;
            flags_q    <= 3'b000;
        end else begin
            outValid_q <= outValid_d;
            outExp_q   <= outExp_d;
            outMan_q   <= outMan_d;
            flags_q    <= flags_d;
        end
    end

    assign out_valid = outValid_q;
    assign output_e  = outExp_q;
    assign output_m  = outMan_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_normaliser_pipe.sv
// Self-checking bench for fp_normaliser_pipe: directed corner cases, stalls, reset and random traffic.
// Expected results come from an arithmetic model of the normalisation rules.
module tb_fp_normaliser_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  input_e;
    logic [24:0] input_m;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  output_e;
    logic [24:0] output_m;
    logic [2:0]  flags;

    int total = 0;
    int bad   = 0;
    logic [35:0] sbq[$];

    fp_normaliser_pipe #(.EXP_W(8), .MAN_W(25)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .input_e(input_e), .input_m(input_m),
        .out_valid(out_valid), .out_ready(out_ready),
        .output_e(output_e), .output_m(output_m), .flags(flags)
    );

    always #5 clk = ~clk;

    // Result packed as {flags, exponent, mantissa}.
    function automatic logic [35:0] refModel(input logic [7:0] e, input logic [24:0] m);
        longint mi, rm;
        int ei, p, l;
        mi = longint'(m);
        ei = int'(e);
        if (mi == 0) return {3'b001, 8'h00, 25'h0};
        if (mi >= 64'd16777216) begin
            if (ei + 1 >= 255) return {3'b100, 8'hFF, 25'h0};
            rm = mi / 2;
`ifdef NORM_STICKY_EN
            if (mi % 2 == 1) rm = rm | 64'd1;
`endif
            return {3'b000, 8'(ei + 1), 25'(rm)};
        end
        p = 0;
        while (mi >= (longint'(1) << (p + 1))) p++;
        l = 23 - p;
        if (l >= ei) return {3'b010, 8'h00, 25'h0};
        rm = mi * (longint'(1) << l);
        return {3'b000, 8'(ei - l), 25'(rm)};
    endfunction

    task automatic genOperand(output logic [7:0] e, output logic [24:0] m);
        logic [7:0] edges [4];
        edges[0] = 8'h00; edges[1] = 8'h01; edges[2] = 8'hFE; edges[3] = 8'hFF;
        case ($urandom_range(0, 5))
            0: m = 25'h0;
            1: m = 25'h1000000 | 25'($urandom_range(0, 32'hFFFFFF));
            2: m = 25'h0800000 | 25'($urandom_range(0, 32'h7FFFFF));
            3, 4: m = (25'($urandom) & 25'h0FFFFFF) >> $urandom_range(0, 23);
            default: m = 25'($urandom);
        endcase
        case ($urandom_range(0, 4))
            0: e = edges[$urandom_range(0, 3)];
            1: e = 8'($urandom_range(0, 30));
            default: e = 8'($urandom);
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        input_e = 8'hAA; input_m = 25'h1234567;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (output_e !== 8'h00) begin bad++; $display("[TB] FAIL reset_e got=%h want=00", output_e); end
        total++; if (output_m !== 25'h0) begin bad++; $display("[TB] FAIL reset_m got=%h want=0", output_m); end
        total++; if (flags !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags got=%b want=000", flags); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [7:0]  dE [6];
        logic [24:0] dM [6];
        logic [35:0] dExp [6];
        dE[0] = 8'h80; dM[0] = 25'h0000008; dExp[0] = {3'b000, 8'h6C, 25'h0800000};
`ifdef NORM_STICKY_EN
        dE[1] = 8'h80; dM[1] = 25'h1800001; dExp[1] = {3'b000, 8'h81, 25'h0C00001};
`else
        dE[1] = 8'h80; dM[1] = 25'h1800001; dExp[1] = {3'b000, 8'h81, 25'h0C00000};
`endif
        dE[2] = 8'h05; dM[2] = 25'h0000100; dExp[2] = {3'b010, 8'h00, 25'h0};
        dE[3] = 8'h40; dM[3] = 25'h0000000; dExp[3] = {3'b001, 8'h00, 25'h0};
        dE[4] = 8'hFE; dM[4] = 25'h1000000; dExp[4] = {3'b100, 8'hFF, 25'h0};
        dE[5] = 8'h40; dM[5] = 25'h0ABCDEF; dExp[5] = {3'b000, 8'h40, 25'h0ABCDEF};
        for (int k = 0; k < 6; k++) begin
            input_e = dE[k]; input_m = dM[k]; in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL dir%0d_accept in_ready=%b want=1", k, in_ready); end
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL dir%0d_early out_valid=%b want=0", k, out_valid); end
            @(posedge clk);
            @(negedge clk);
            total++;
            if ({out_valid, flags, output_e, output_m} !== {1'b1, dExp[k]}) begin
                bad++;
                $display("[TB] FAIL dir%0d_result got v=%b f=%b e=%h m=%h want v=1 f=%b e=%h m=%h",
                         k, out_valid, flags, output_e, output_m, dExp[k][35:33], dExp[k][32:25], dExp[k][24:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vE [4];
        logic [24:0] vM [4];
        logic [35:0] expQ[$];
        logic [35:0] snap, exp;
        int sent = 0, outs = 0, firstBlock = -1, lastOut = -1;
        logic acc, holding;
        holding = 1'b0;
        snap = '0;
        for (int i = 0; i < 4; i++) begin
            genOperand(vE[i], vM[i]);
            expQ.push_back(refModel(vE[i], vM[i]));
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (sent < 4);
            if (sent < 4) begin input_e = vE[sent]; input_m = vM[sent]; end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (in_valid && !in_ready && firstBlock < 0) firstBlock = sent;
            if (holding) begin
                total++;
                if ({out_valid, flags, output_e, output_m} !== {1'b1, snap}) begin
                    bad++;
                    $display("[TB] FAIL b2b_hold cyc=%0d got v=%b %h want v=1 %h", cyc, out_valid, {flags, output_e, output_m}, snap);
                end
            end
            holding = out_valid && !out_ready;
            snap = {flags, output_e, output_m};
            if (out_valid && out_ready) begin
                exp = (expQ.size() > 0) ? expQ.pop_front() : 36'h0;
                total++;
                if ({flags, output_e, output_m} !== exp) begin
                    bad++;
                    $display("[TB] FAIL b2b_data%0d got=%h want=%h", outs, {flags, output_e, output_m}, exp);
                end
                if (lastOut >= 0) begin
                    total++;
                    if (cyc != lastOut + 1) begin bad++; $display("[TB] FAIL b2b_rate cyc=%0d want=%0d", cyc, lastOut + 1); end
                end
                lastOut = cyc;
                outs++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        total++; if (firstBlock != 2) begin bad++; $display("[TB] FAIL b2b_block accepts=%0d want=2", firstBlock); end
        total++; if (outs != 4) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=4", outs); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0; in_valid = 1'b1;
        input_e = 8'h80; input_m = 25'h0000008;
        @(posedge clk); #1;
        input_e = 8'h70; input_m = 25'h1800001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL midrst_inflight out_valid=%b want=1", out_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_in_ready got=%b want=1", in_ready); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_stale cyc=%0d out_valid=%b want=0", i, out_valid); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        localparam int N = 400;
        sbq.delete();
        fork
            begin
                logic [7:0]  e;
                logic [24:0] m;
                logic acc;
                int guard;
                for (int i = 0; i < N; i++) begin
                    genOperand(e, m);
                    while ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    in_valid = 1'b1; input_e = e; input_m = m;
                    guard = 0;
                    do begin
                        @(negedge clk);
                        acc = in_ready;
                        if (acc) sbq.push_back(refModel(e, m));
                        @(posedge clk); #1;
                        guard++;
                    end while (!acc && guard < 6000);
                end
                in_valid = 1'b0;
            end
            begin
                int got = 0, cyc = 0;
                logic [35:0] exp;
                while (got < N && cyc < 8000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        total++;
                        if (sbq.size() == 0) begin
                            bad++;
                            $display("[TB] FAIL rand_spurious got=%h want=none", {flags, output_e, output_m});
                        end else begin
                            exp = sbq.pop_front();
                            if ({flags, output_e, output_m} !== exp) begin
                                bad++;
                                $display("[TB] FAIL rand_data%0d got f=%b e=%h m=%h want f=%b e=%h m=%h",
                                         got, flags, output_e, output_m, exp[35:33], exp[32:25], exp[24:0]);
                            end
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                if (got < N) begin
                    total++; bad++;
                    $display("[TB] FAIL rand_timeout got=%0d want=%0d", got, N);
                end
            end
        join
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        input_e = '0; input_m = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
